burst_mem_bridge: RTL and testbench

//  Sits directly downstream of the CPU cache, on its lowmem side. Turns cache line bursts
//  (burst_en=1) and pass-through single accesses (burst_en=0) into one-word req/ack

---
 rtl/burst_mem_bridge.sv | 148 ++++++++++++++
 tb/tb_burst_mem_bridge.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_mem_bridge.sv
// rtl/burst_mem_bridge.sv - cache-line burst to one-word req/ack memory bus bridge
module burst_mem_bridge #(
    parameter int WR_DATA_LAT = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        burst_en_i,
    input  logic [7:0]  burst_length_i,
    input  logic [31:0] up_a_i,
    input  logic [31:0] up_d_i,
    input  logic        up_we_i,
    input  logic        up_rd_i,
    output logic [31:0] up_spo_o,
    output logic        up_ready_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_a_o,
    output logic [31:0] mem_d_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    localparam int LAT_W = $clog2(WR_DATA_LAT + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RD_GAP,
        S_WR_LAT,
        S_WR
    } state_t;

    state_t             state_q;
    logic [31:0]        base_q;
    logic [7:0]         len_q;
    logic [7:0]         cnt_q;
    logic               burst_q;
    logic [LAT_W-1:0]   lat_q;
    logic               strobe_q;
    logic               mem_req_q;
    logic               mem_we_q;
    logic [31:0]        mem_a_q;
    logic [31:0]        mem_d_q;
    logic [31:0]        up_spo_q;

    logic [31:0]        word_a_d;
    logic [7:0]         cnt_d;
    logic               last_d;

    // Word address wraps naturally in 32-bit arithmetic.
    assign word_a_d = base_q + {22'd0, cnt_q, 2'b00};
    assign cnt_d    = cnt_q + 8'd1;
    assign last_d   = !burst_q || (cnt_q == len_q - 8'd1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            len_q     <= 8'd1;
            cnt_q     <= '0;
            burst_q   <= 1'b0;
            lat_q     <= '0;
            strobe_q  <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_a_q   <= '0;
            mem_d_q   <= '0;
            up_spo_q  <= '0;
        end else begin
            strobe_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (up_we_i || up_rd_i) begin
                        base_q  <= up_a_i;
                        len_q   <= (burst_length_i == 8'd0) ? 8'd1 : burst_length_i;
                        burst_q <= burst_en_i;
                        cnt_q   <= '0;
                        lat_q   <= '0;
                        mem_a_q <= up_a_i;
                        if (up_we_i) begin
                            if (burst_en_i) begin
                                state_q <= S_WR_LAT;
                            end else begin
                                mem_d_q   <= up_d_i;
                                mem_req_q <= 1'b1;
                                mem_we_q  <= 1'b1;
                                state_q   <= S_WR;
                            end
                        end else begin
                            mem_req_q <= 1'b1;
                            mem_we_q  <= 1'b0;
                            state_q   <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (mem_ack_i) begin
                        up_spo_q  <= mem_rdata_i;
                        strobe_q  <= 1'b1;
                        cnt_q     <= cnt_d;
                        mem_req_q <= 1'b0;
                        state_q   <= last_d ? S_IDLE : S_RD_GAP;
                    end
                end
                // One idle bus cycle keeps up_spo steady while the cache consumes the strobe.
                S_RD_GAP: begin
                    mem_req_q <= 1'b1;
                    mem_a_q   <= word_a_d;
                    state_q   <= S_RD;
                end
                S_WR_LAT: begin
                    if (lat_q == LAT_W'(WR_DATA_LAT)) begin
                        mem_d_q   <= up_d_i;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b1;
                        mem_a_q   <= word_a_d;
                        state_q   <= S_WR;
                    end else begin
                        lat_q <= lat_q + LAT_W'(1);
                    end
                end
                S_WR: begin
                    if (mem_ack_i) begin
                        strobe_q  <= 1'b1;
                        cnt_q     <= cnt_d;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        lat_q     <= '0;
                        state_q   <= last_d ? S_IDLE : S_WR_LAT;
                    end
                end
                default: begin
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign up_ready_o = strobe_q | ((state_q == S_IDLE) & !burst_en_i);
    assign up_spo_o   = up_spo_q;
    assign mem_req_o  = mem_req_q;
    assign mem_we_o   = mem_we_q;
    assign mem_a_o    = mem_a_q;
    assign mem_d_o    = mem_d_q;

endmodule

// File: tb/tb_burst_mem_bridge.sv
// tb/tb_burst_mem_bridge.sv - randomized bench for burst_mem_bridge with a bus-level reference model
module tb_burst_mem_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        burst_en;
    logic [7:0]  burst_length;
    logic [31:0] up_a;
    logic [31:0] up_d;
    logic        up_we;
    logic        up_rd;
    logic [31:0] up_spo;
    logic        up_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_d;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    always #5 clk = ~clk;

    burst_mem_bridge #(.WR_DATA_LAT(2)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .burst_en_i     (burst_en),
        .burst_length_i (burst_length),
        .up_a_i         (up_a),
        .up_d_i         (up_d),
        .up_we_i        (up_we),
        .up_rd_i        (up_rd),
        .up_spo_o       (up_spo),
        .up_ready_o     (up_ready),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_a_o        (mem_a),
        .mem_d_o        (mem_d),
        .mem_rdata_i    (mem_rdata),
        .mem_ack_i      (mem_ack)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory responder and observation state
    int          cyc = 0;
    int          ack_delay_cfg = 0;
    int          cur_delay = 0;
    int          wait_cnt = 0;
    bit          use_fixed_rd = 0;
    logic [31:0] fixed_rd = '0;
    logic [31:0] txn_a[$];
    logic        txn_we[$];
    logic [31:0] txn_d[$];
    logic [31:0] rd_data[$];
    int          strobes = 0;
    int          last_strobe_cyc = 0;
    bit          prev_strobe = 0;
    logic [31:0] prev_exp_spo = '0;
    logic [31:0] model_spo = '0;
    int          wd_cd = 0;
    bit          cur_is_rd = 0;
    bit          req_pending = 0;

    function automatic int pick_delay();
        return (ack_delay_cfg < 0) ? int'($urandom_range(0, 3)) : ack_delay_cfg;
    endfunction

    task automatic step();
        logic [31:0] rd;
        @(posedge clk);
        #1;
        cyc++;
        mem_ack = 1'b0;
        if (prev_strobe && cur_is_rd)
            check_eq("spo_hold", up_spo, prev_exp_spo);
        prev_strobe = 0;
        if (wd_cd > 0) begin
            wd_cd--;
            if (wd_cd == 0) up_d = up_d + 32'd1;
        end
        if (burst_en && up_ready) begin
            if (strobes > 0)
                check_eq("strobe_spacing", 32'(cyc - last_strobe_cyc >= 2), 32'd1);
            if (cur_is_rd) begin
                if (strobes < rd_data.size()) begin
                    check_eq("strobe_spo", up_spo, rd_data[strobes]);
                    prev_exp_spo = rd_data[strobes];
                end else begin
                    check_eq("strobe_without_ack", 32'(strobes), 32'(rd_data.size()));
                end
            end else begin
                wd_cd = 2;
            end
            strobes++;
            last_strobe_cyc = cyc;
            prev_strobe = 1;
        end
        if (req_pending)
            check_eq("req_held", {31'd0, mem_req}, 32'd1);
        req_pending = 0;
        if (mem_req) begin
            if (wait_cnt >= cur_delay) begin
                rd = use_fixed_rd ? fixed_rd : $urandom;
                mem_ack   = 1'b1;
                mem_rdata = rd;
                txn_a.push_back(mem_a);
                txn_we.push_back(mem_we);
                txn_d.push_back(mem_d);
                rd_data.push_back(rd);
                wait_cnt  = 0;
                cur_delay = pick_delay();
            end else begin
                wait_cnt++;
                req_pending = 1;
            end
        end
    endtask

    task automatic issue(input bit is_wr, input bit both, input bit burst,
                         input logic [31:0] addr, input logic [7:0] blen, input logic [31:0] d0);
        txn_a.delete(); txn_we.delete(); txn_d.delete(); rd_data.delete();
        strobes = 0; wd_cd = 0; wait_cnt = 0; req_pending = 0; prev_strobe = 0;
        cur_delay = pick_delay();
        cur_is_rd = !is_wr;
        burst_en = burst; up_a = addr; burst_length = blen; up_d = d0;
        up_we = is_wr; up_rd = !is_wr || both;
        step();
        up_we = 1'b0; up_rd = 1'b0;
        up_a = $urandom; burst_length = 8'($urandom);
        if (!burst) up_d = $urandom;
    endtask

    task automatic run_txn(input string name, input bit is_wr, input bit both, input bit burst,
                           input logic [31:0] addr, input logic [7:0] blen, input logic [31:0] d0);
        int n;
        int budget;
        int m;
        n = burst ? ((blen == 8'd0) ? 1 : int'(blen)) : 1;
        issue(is_wr, both, burst, addr, blen, d0);
        if (!burst) check_eq({name, "_busy_ready"}, {31'd0, up_ready}, 32'd0);
        budget = 0;
        while (txn_a.size() < n && budget < 4000) begin
            step();
            budget++;
        end
        repeat (4) step();
        check_eq({name, "_words"}, 32'(txn_a.size()), 32'(n));
        m = (txn_a.size() < n) ? txn_a.size() : n;
        for (int i = 0; i < m; i++) begin
            check_eq({name, "_addr"}, txn_a[i], addr + 32'(4 * i));
            check_eq({name, "_we"}, {31'd0, txn_we[i]}, {31'd0, is_wr});
            if (is_wr) check_eq({name, "_wdata"}, txn_d[i], d0 + 32'(i));
        end
        if (burst) begin
            check_eq({name, "_strobes"}, 32'(strobes), 32'(n));
        end else begin
            check_eq({name, "_idle_ready"}, {31'd0, up_ready}, 32'd1);
            if (!is_wr && rd_data.size() > 0) check_eq({name, "_spo"}, up_spo, rd_data[0]);
        end
        if (!is_wr && rd_data.size() > 0) model_spo = rd_data[rd_data.size() - 1];
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int budget;
        int s;
        rst_n = 1'b0; burst_en = 1'b0; burst_length = '0; up_a = '0; up_d = '0;
        up_we = 1'b0; up_rd = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_eq("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check_eq("rst_mem_a", mem_a, 32'd0);
        check_eq("rst_mem_d", mem_d, 32'd0);
        check_eq("rst_up_spo", up_spo, 32'd0);
        check_eq("rst_up_ready", {31'd0, up_ready}, 32'd1);
        rst_n = 1'b1;

        use_fixed_rd = 1; fixed_rd = 32'hDEADBEEF; ack_delay_cfg = 3;
        run_txn("single_rd", 0, 0, 0, 32'h0000_0100, 8'd0, 32'd0);
        check_eq("single_rd_value", up_spo, 32'hDEADBEEF);
        use_fixed_rd = 0;

        ack_delay_cfg = 0;
        run_txn("burst_rd32", 0, 0, 1, 32'h2000_0080, 8'd32, 32'd0);

        ack_delay_cfg = -1;
        run_txn("burst_wr4", 1, 0, 1, 32'h0000_4000, 8'd4, 32'h0000_00A0);

        run_txn("we_rd_both", 1, 1, 0, 32'h0000_0200, 8'd0, 32'h0000_0055);

        // Spurious ack while idle must not disturb anything.
        burst_en = 1'b1;
        step();
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        step();
        check_eq("stray_ack_spo", up_spo, model_spo);
        check_eq("stray_ack_ready", {31'd0, up_ready}, 32'd0);
        check_eq("stray_ack_req", {31'd0, mem_req}, 32'd0);

        // Reset in the middle of word 10 of a 32-word read.
        ack_delay_cfg = 1;
        issue(0, 0, 1, 32'h0000_8000, 8'd32, 32'd0);
        budget = 0;
        while (strobes < 10 && budget < 2000) begin step(); budget++; end
        while (!mem_req && budget < 2000) begin step(); budget++; end
        check_eq("abort_reached_word10", 32'(strobes), 32'd10);
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_req", {31'd0, mem_req}, 32'd0);
        check_eq("abort_spo", up_spo, 32'd0);
        check_eq("abort_mem_a", mem_a, 32'd0);
        s = strobes; req_pending = 0; wait_cnt = 0; prev_strobe = 0;
        repeat (3) step();
        check_eq("abort_no_strobe", 32'(strobes), 32'(s));
        check_eq("abort_no_req", {31'd0, mem_req}, 32'd0);
        rst_n = 1'b1;
        ack_delay_cfg = -1;
        run_txn("post_rst_rd4", 0, 0, 1, 32'h0000_9000, 8'd4, 32'd0);

        run_txn("len0", 0, 0, 1, 32'h0000_0300, 8'd0, 32'd0);
        run_txn("wrap_rd4", 0, 0, 1, 32'hFFFF_FFF8, 8'd4, 32'd0);
        run_txn("wrap_wr4", 1, 0, 1, 32'hFFFF_FFF8, 8'd4, 32'h0000_0C00);

        for (int t = 0; t < 16; t++) begin
            logic [31:0] ra;
            ra = {$urandom, 2'b00};
            run_txn("rand", 1'($urandom), 1'($urandom), 1'($urandom), ra,
                    8'($urandom_range(0, 9)), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
